// File: rtl/free_running_timer.sv
// free_running_timer
//   Programmable free-running tick generator. An up-counter runs from 0 to the
//   run-time limit max_cnt and then wraps to 0. A registered one-clock tick is
//   emitted on every wrap, so the tick period is max_cnt+1 enabled cycles.
//   Holding enable low freezes the counter, so no phase is lost, and the tick
//   is suppressed for that time.
module free_running_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,    // asynchronous, active-low
  input  logic             enable,
  input  logic [WIDTH-1:0] max_cnt,
  output logic             tick
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             tick_q;
  logic             tick_d;

  // Next-state logic. The compare is ">=" rather than "==" on purpose. If
  // max_cnt is lowered below the current count, the counter wraps on the next
  // enabled edge instead of running on to 2^WIDTH.
  always_comb begin
    count_d = count_q;
    tick_d  = 1'b0;
    if (enable) begin
      if (count_q >= max_cnt) begin
        count_d = '0;
        tick_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  // State register. Reset clears count and tick at once, without a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: tb/tb_free_running_timer.sv
// tb_free_running_timer
//   Drives directed scenarios and then random stimulus. Every falling edge
//   compares tick and the internal count against a reference model.
//   Hand-computed tick periods fix the model to known values.
module tb_free_running_timer;

  localparam int WIDTH = 8;

  logic             clk     = 1'b0;
  logic             reset   = 1'b1;
  logic             enable  = 1'b0;
  logic [WIDTH-1:0] max_cnt = '0;
  logic             tick;

  int checks = 0;
  int errors = 0;
  int n;

  // Reference model state. It uses unbounded integer arithmetic.
  int m_count = 0;
  bit m_tick  = 1'b0;

  always #10 clk = ~clk;

  free_running_timer #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .max_cnt (max_cnt),
    .tick    (tick)
  );

  // Reference model. It counts enabled edges and wraps once the limit is reached.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_count <= 0;
      m_tick  <= 1'b0;
    end else if (enable) begin
      if (m_count >= int'(max_cnt)) begin
        m_count <= 0;
        m_tick  <= 1'b1;
      end else begin
        m_count <= m_count + 1;
        m_tick  <= 1'b0;
      end
    end else begin
      m_tick <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT against the model.
  task automatic cycle();
    @(negedge clk);
    chk("tick_vs_model", int'(tick), int'(m_tick));
    chk("count_vs_model", int'(dut.count_q), m_count);
  endtask

  // Count falling edges until tick is seen high. The wait is bounded.
  task automatic wait_tick(output int cycles);
    cycles = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle();
      cycles++;
      if (tick) return;
    end
    checks++;
    errors++;
    $display("FAIL wait_tick: no tick within 1000 cycles, required one");
    cycles = -1;
  endtask

  // Driver. All stimulus and all comparisons run in this one process.
  initial begin
    // Scenario 1: reset held low, first with enable=0 and then with enable=1.
    #1 reset = 1'b0;
    enable = 1'b0;
    max_cnt = 8'd27;
    repeat (3) begin
      cycle();
      chk("reset_tick_en0", int'(tick), 0);
    end
    enable = 1'b1;
    repeat (3) begin
      cycle();
      chk("reset_count_en1", int'(dut.count_q), 0);
    end

    // Scenario 2: release with max_cnt=27. The first tick comes 28 edges
    // after release, lasts one cycle, and then repeats every 28 cycles.
    reset = 1'b1;
    wait_tick(n);
    chk("first_tick_edges", n, 28);
    cycle();
    chk("tick_one_wide", int'(tick), 0);
    wait_tick(n);
    chk("period_after_width", n, 27);
    wait_tick(n);
    chk("period_27", n, 28);

    // Scenario 3: raise max_cnt to 28 right after a wrap. The period becomes 29.
    max_cnt = 8'd28;
    wait_tick(n);
    chk("period_28_a", n, 29);
    wait_tick(n);
    chk("period_28_b", n, 29);
    max_cnt = 8'd27;
    wait_tick(n);
    chk("period_back_27", n, 28);

    // Scenario 4: lower max_cnt to 5 while count=20. The counter wraps on the
    // next edge, and the period is then 6.
    repeat (20) cycle();
    chk("count_at_20", int'(dut.count_q), 20);
    max_cnt = 8'd5;
    wait_tick(n);
    chk("lower_wrap_next_edge", n, 1);
    wait_tick(n);
    chk("period_5", n, 6);

    // Scenario 5: pause for 10 cycles mid-count. The next tick is 10 cycles late.
    max_cnt = 8'd27;
    wait_tick(n);
    chk("period_27_again", n, 28);
    repeat (5) cycle();
    enable = 1'b0;
    repeat (10) begin
      cycle();
      chk("paused_tick", int'(tick), 0);
      chk("paused_count", int'(dut.count_q), 5);
    end
    enable = 1'b1;
    wait_tick(n);
    chk("resume_remaining", n, 23);

    // Scenario 6: with max_cnt=0 there is a tick on every enabled cycle.
    max_cnt = 8'd0;
    repeat (4) begin
      wait_tick(n);
      chk("max0_every_cycle", n, 1);
    end
    // Assert reset mid-cycle. The DUT must clear without waiting for a clock edge.
    #7 reset = 1'b0;
    #1;
    chk("async_reset_tick", int'(tick), 0);
    chk("async_reset_count", int'(dut.count_q), 0);
    repeat (2) cycle();
    max_cnt = 8'd255;
    reset = 1'b1;
    wait_tick(n);
    chk("period_255_first", n, 256);
    wait_tick(n);
    chk("period_255", n, 256);

    // Random phase: random enable, limit changes and occasional reset.
    repeat (3000) begin
      cycle();
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) begin
        if ($urandom_range(0, 3) == 0) max_cnt = 8'($urandom_range(0, 255));
        else                           max_cnt = 8'($urandom_range(0, 15));
      end
      if (!reset) begin
        reset = 1'b1;
      end else if ($urandom_range(0, 199) == 0) begin
        #4 reset = 1'b0;
        #1;
        chk("rand_async_tick", int'(tick), 0);
        chk("rand_async_count", int'(dut.count_q), 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
